// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sweep/capture block: width defaults, opcode
// encoding and the sweep FSM state type.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int SEL_W_DEFAULT  = 4;
    localparam int SWEEP_DEPTH    = 2 ** SEL_W_DEFAULT;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU used to cross-check captured results.
// Returns {carry, result}; carry is the unsigned add carry for every opcode.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int SEL_W  = SEL_W_DEFAULT
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W:0]   res
);

    localparam int SH_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [3:0]          op;
    logic [SH_W-1:0]     sh;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] rot_l;
    logic [2*DATA_W-1:0] rot_r;
    logic [DATA_W-1:0]   r;

    assign op  = 4'(sel);
    assign sh  = b[SH_W-1:0];
    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        // Rotates are shifts of the operand concatenated with itself.
        rot_l = {a, a} << sh;
        rot_r = {a, a} >> sh;
        r     = '0;
        case (alu_op_e'(op))
            OP_ADD:  r = sum[DATA_W-1:0];
            OP_SUB:  r = a - b;
            OP_MUL:  r = prod[DATA_W-1:0];
            OP_DIV:  r = (b == '0) ? {DATA_W{1'b1}} : a / b;
            OP_SHL:  r = a << sh;
            OP_SHR:  r = a >> sh;
            OP_ROL:  r = rot_l[2*DATA_W-1:DATA_W];
            OP_ROR:  r = rot_r[DATA_W-1:0];
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_GT:   r = {{(DATA_W-1){1'b0}}, (a > b)};
            OP_EQ:   r = {{(DATA_W-1){1'b0}}, (a == b)};
            default: r = '0;
        endcase
    end

    assign res = {sum[DATA_W], r};

endmodule

// File: rtl/alu_sweep_capture.sv
// Sweeps an external ALU through every opcode for one operand pair and
// captures {carry, result} per opcode. Optional checker: ALU_SWEEP_CHECK_EN.
module alu_sweep_capture
    import alu_pkg::*;
#(
    parameter int DATA_W        = DATA_W_DEFAULT,
    parameter int SEL_W         = SEL_W_DEFAULT,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              carry_out,
    output logic              busy,
    output logic              done,
    input  logic [SEL_W-1:0]  rd_addr,
    output logic [DATA_W:0]   rd_data,
`ifdef ALU_SWEEP_CHECK_EN
    output logic [2**SEL_W-1:0] err_mask,
`endif
    output sweep_state_e      state_dbg
);

    localparam int DEPTH = 2 ** SEL_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};

    // Handshake: start is a level sampled only in IDLE; once accepted, busy
    // stays high until the last capture and done pulses for exactly one cycle
    // afterwards. start seen in any other state is dropped without effect.

    sweep_state_e      state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] alu_a_n, alu_b_n;
    logic [SEL_W-1:0]  alu_sel_n;
    logic              busy_n, done_n;
    logic              wr_en;
    logic              start_acc;

    logic [DATA_W:0]   mem [DEPTH];

    assign state_dbg = state;
    assign start_acc = (state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_sel <= alu_sel_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        alu_a_n   = alu_a;
        alu_b_n   = alu_b;
        alu_sel_n = alu_sel;
        busy_n    = busy;
        done_n    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    alu_a_n   = op_a;
                    alu_b_n   = op_b;
                    alu_sel_n = '0;
                    cnt_n     = '0;
                    busy_n    = 1'b1;
                    state_n   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_n = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                wr_en = 1'b1;
                if (alu_sel == SEL_LAST) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = ST_DONE;
                end else begin
                    alu_sel_n = alu_sel + SEL_W'(1);
                    cnt_n     = '0;
                    state_n   = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Read and write share the edge, so a same-address read returns old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[alu_sel] <= {carry_out, alu_out};
            end
            rd_data <= mem[rd_addr];
        end
    end

`ifdef ALU_SWEEP_CHECK_EN
    logic [DATA_W:0] ref_res;

    alu_ref_model #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_ref_model (
        .a   (alu_a),
        .b   (alu_b),
        .sel (alu_sel),
        .res (ref_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mask <= '0;
        end else if (start_acc) begin
            err_mask <= '0;
        end else if (wr_en && (ref_res != {carry_out, alu_out})) begin
            err_mask[alu_sel] <= 1'b1;
        end
    end
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: doc/alu_sweep_capture.md
Name: alu_sweep_capture

Overview:
Hardware sweep engine, the capture side of the ALU interface. On `start` it latches one operand pair and drives it into the combinational ALU. It steps the ALU select through all 16 opcodes, waits a fixed settle interval per opcode, then stores {CarryOut, ALU_Out} into a 16-entry result buffer. The buffer is readable by a host/debug port. Used for on-chip ALU self-test and bring-up, replacing bench-driven select sweeps.

Parameters:
DATA_W, 8, operand/result width
SEL_W, 4, opcode width; buffer depth = 2**SEL_W
SETTLE_CYCLES, 2, cycles each opcode is held before capture; legal range >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  sweep request; sampled only in IDLE
op_a  input  DATA_W  operand A; latched on accepted start
op_b  input  DATA_W  operand B; latched on accepted start
alu_a  output  DATA_W  to ALU input A
alu_b  output  DATA_W  to ALU input B
alu_sel  output  SEL_W  to ALU opcode select
alu_out  input  DATA_W  from ALU result
carry_out  input  1  from ALU carry
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
rd_addr  input  SEL_W  buffer read address
rd_data  output  DATA_W+1  {carry, result}; 1-cycle registered read

Behaviour:
- Reset (async, active-high): state=IDLE; alu_a, alu_b, alu_sel, busy, done, rd_data = 0; all buffer entries = 0; settle counter = 0.
- FSM has four states: IDLE, DRIVE, CAPTURE, DONE.
- IDLE: on a clk edge with start=1:
  - alu_a<=op_a, alu_b<=op_b, alu_sel<=0, cnt<=0.
  - Go to DRIVE; busy<=1.
- DRIVE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, go to CAPTURE.
- CAPTURE: mem[alu_sel]<={carry_out, alu_out}.
  - If alu_sel==2**SEL_W-1: go to DONE, busy<=0, done<=1.
  - Else: alu_sel<=alu_sel+1, cnt<=0, go to DRIVE.
- DONE: done<=0, go to IDLE. alu_a, alu_b, alu_sel hold their last values.
- Timing: with start accepted at edge t0, opcode k is captured at edge t0+(k+1)(SETTLE_CYCLES+1). done is high for exactly the cycle after the final capture edge.
- start while busy or in DONE: ignored, with no effect on operands or sequence.
- rd_data<=mem[rd_addr] on every edge in any state. A read of the entry written on the same edge returns the old value.
- Buffer contents persist across sweeps until overwritten or reset.
- Reset mid-sweep: immediate return to IDLE with all state and the buffer cleared; no done pulse.

Optional Feature:
Macro ALU_SWEEP_CHECK_EN.
- Defined: adds an internal reference model (opcode encoding from the package) evaluated on alu_a/alu_b/alu_sel.
  - In CAPTURE, the result is compared with the model.
  - Mismatches go to output err_mask[2**SEL_W-1:0], one bit per opcode, set on mismatch.
  - err_mask is cleared on reset and on each accepted start.
- Undefined: no model, no err_mask port.

Decomposition:
- Package alu_pkg holds DATA_W/SEL_W defaults, the opcode enum, and the SWEEP_DEPTH constant.
- Opcode enum order: ADD, SUB, MUL, DIV, SHL, SHR, ROL, ROR, AND, OR, XOR, NOR, NAND, XNOR, GT, EQ.
- Carry is bit DATA_W of the zero-extended op_a+op_b, independent of opcode.
- One sub-module, alu_ref_model, pure combinational, instantiated only under ALU_SWEEP_CHECK_EN.

Test Plan:
- Reset then idle: rd_data=0 at all 16 addresses; busy=0, done=0, alu_sel=0.
- op_a=13, op_b=1, start; ALU stub returns ADD 14, SUB 12, MUL 13, AND 1, EQ 0.
  - Required: busy for 48 cycles, done pulse at cycle 49.
  - Reads: addr0=0x00E, addr1=0x00C, addr8=0x001, addr15=0x000.
- op_a=255, op_b=1, ADD: addr0 = {1, 0x00}, i.e. carry set; alu_sel visibly steps 0..15, each held 3 cycles.
- start pulsed repeatedly mid-sweep with new operands: alu_a/alu_b unchanged, single done pulse, sweep length unchanged.
- Assert rst at cycle 20 of a sweep: busy=0 and alu_sel=0 immediately, no done pulse, all reads return 0.
- With ALU_SWEEP_CHECK_EN and a stub corrupting XOR only: err_mask=0x0400 after done; a new start clears err_mask to 0.
